// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: ping-pong frame buffer for the camera capture path.
// The capture side writes one bank while the display side reads the other.
// The banks swap once both sides have signalled end-of-frame. After reset or
// clear_req, an auto-clear sequencer fills every bank with CLR_VAL.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   clear_req          pulse: restart the clear sequence (ignored while busy)
//   wr_en/addr/data    capture-side write port
//   wr_frame_end       pulse: writer finished its frame
//   rd_en/addr         display-side read port
//   rd_frame_end       pulse: reader finished its frame
//   rd_data, rd_valid  read result, READ_LAT cycles after rd_en
//   busy               clear sequence in progress
//   wr_bank, rd_bank   banks currently written / read
//   swap_pending       writer finished, waiting on reader
//   overrun            sticky: writer accessed while swap pending
module frame_buffer_pp #(
    parameter int unsigned   AW       = 15,
    parameter int unsigned   DW       = 12,
    parameter int unsigned   DUAL     = 1,
    parameter int unsigned   READ_LAT = 1,
    parameter logic [DW-1:0] CLR_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_frame_end,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_frame_end,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          wr_bank,
    output logic          rd_bank,
    output logic          swap_pending,
    output logic          overrun
);

    localparam int unsigned DEPTH        = 2**AW;
    localparam int unsigned NB           = (DUAL != 0) ? 2 : 1;
    localparam logic [AW:0] CLR_LAST     = (AW+1)'(DEPTH - 1);
    localparam logic        RD_BANK_INIT = (DUAL != 0);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    state;
    logic [AW:0]   clr_addr;
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic          wr_done;
    logic          rd_done;
    logic          overrun_q;
    logic          run;
    logic          do_wr;
    logic          do_rd;
    logic [DW-1:0] bank_rd [NB];
    logic [DW-1:0] rd_mem;
    logic          s1_valid;
    logic [DW-1:0] s1_data;

    assign run   = (state == ST_RUN);
    // A write is only accepted while the writer's bank is not awaiting a swap.
    assign do_wr = run && wr_en && !wr_done;
    assign do_rd = run && rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= RD_BANK_INIT;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == CLR_LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        clr_addr  <= '0;
                        wr_bank_q <= 1'b0;
                        rd_bank_q <= RD_BANK_INIT;
                        wr_done   <= 1'b0;
                        rd_done   <= 1'b0;
                        overrun_q <= 1'b0;
                    end else if (DUAL != 0) begin
                        if (wr_done && (wr_en || wr_frame_end)) begin
                            overrun_q <= 1'b1;
                        end
                        // Frame-end pulses arriving on the swap cycle itself are absorbed.
                        if (wr_done && rd_done) begin
                            wr_bank_q <= !wr_bank_q;
                            rd_bank_q <= !rd_bank_q;
                            wr_done   <= 1'b0;
                            rd_done   <= 1'b0;
                        end else begin
                            if (wr_frame_end) wr_done <= 1'b1;
                            if (rd_frame_end) rd_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (!run) begin
                mem[clr_addr[AW-1:0]] <= CLR_VAL;
            end else if (do_wr && (wr_bank_q == 1'(b))) begin
                mem[wr_addr] <= wr_data;
            end
        end

        assign bank_rd[b] = mem[rd_addr];
    end

    if (DUAL != 0) begin : g_rd_dual
        assign rd_mem = rd_bank_q ? bank_rd[1] : bank_rd[0];
    end else begin : g_rd_single
        assign rd_mem = bank_rd[0];
    end

    // The bank is selected at issue, so a read in flight across a swap is
    // unaffected. Sampling here also gives read-before-write on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= do_rd;
            if (do_rd) s1_data <= rd_mem;
        end
    end

    if (READ_LAT >= 2) begin : g_lat2
        logic          s2_valid;
        logic [DW-1:0] s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= s1_data;
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

    assign busy         = !run;
    assign wr_bank      = wr_bank_q;
    assign rd_bank      = rd_bank_q;
    assign swap_pending = wr_done;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_frame_buffer_pp.sv
// tb_frame_buffer_pp: checks frame_buffer_pp in two configurations.
// u_dut is the ping-pong configuration with READ_LAT=1. u_sgl is the
// single-bank configuration with READ_LAT=2.
module tb_frame_buffer_pp;

    localparam logic [11:0] CV = 12'hABC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        clr, we, wfe, re, rfe;
    logic [3:0]  wa, ra;
    logic [11:0] wdat;
    logic [11:0] rdata;
    logic        rv, busy, wb, rb, sp, ovr;

    logic        s_clr, s_we, s_wfe, s_re, s_rfe;
    logic [3:0]  s_wa, s_ra;
    logic [11:0] s_wd;
    logic [11:0] s_rdata;
    logic        s_rv, s_busy, s_wb, s_rb, s_sp, s_ovr;

    int checks = 0;
    int errors = 0;

    // Reference model of u_dut: two frame arrays plus frame accounting.
    logic [11:0] m_ram [2][16];
    bit          m_busy;
    int          m_cnt;
    bit          m_wb, m_rb, m_wd, m_rdn, m_ovr, m_rv;
    logic [11:0] m_rdata;

    typedef struct packed {
        logic        clr, we;
        logic [3:0]  wa;
        logic [11:0] wd;
        logic        wfe, re;
        logic [3:0]  ra;
        logic        rfe;
        logic        e_rv;
        logic [11:0] e_rdata;
        logic        e_wb, e_rb, e_sp, e_ovr;
    } vec_t;

    vec_t tbl [13];

    frame_buffer_pp #(.AW(4), .DW(12), .DUAL(1), .READ_LAT(1), .CLR_VAL(CV)) u_dut (
        .clk(clk), .rst(rst), .clear_req(clr),
        .wr_en(we), .wr_addr(wa), .wr_data(wdat), .wr_frame_end(wfe),
        .rd_en(re), .rd_addr(ra), .rd_frame_end(rfe),
        .rd_data(rdata), .rd_valid(rv), .busy(busy), .wr_bank(wb), .rd_bank(rb),
        .swap_pending(sp), .overrun(ovr)
    );

    frame_buffer_pp #(.AW(4), .DW(12), .DUAL(0), .READ_LAT(2), .CLR_VAL(CV)) u_sgl (
        .clk(clk), .rst(rst), .clear_req(s_clr),
        .wr_en(s_we), .wr_addr(s_wa), .wr_data(s_wd), .wr_frame_end(s_wfe),
        .rd_en(s_re), .rd_addr(s_ra), .rd_frame_end(s_rfe),
        .rd_data(s_rdata), .rd_valid(s_rv), .busy(s_busy), .wr_bank(s_wb), .rd_bank(s_rb),
        .swap_pending(s_sp), .overrun(s_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_wb    = 1'b0;
        m_rb    = 1'b1;
        m_wd    = 1'b0;
        m_rdn   = 1'b0;
        m_ovr   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = '0;
    endtask

    task automatic model_step(input logic c, input logic w, input logic [3:0] a,
                              input logic [11:0] d, input logic fw, input logic r,
                              input logic [3:0] ar, input logic fr);
        if (m_busy) begin
            m_ram[0][m_cnt] = CV;
            m_ram[1][m_cnt] = CV;
            m_cnt++;
            if (m_cnt == 16) m_busy = 1'b0;
            m_rv = 1'b0;
        end else begin
            m_rv = r;
            if (r) m_rdata = m_ram[m_rb][ar];
            if (w) begin
                if (m_wd) m_ovr = 1'b1;
                else      m_ram[m_wb][a] = d;
            end
            if (fw && m_wd) m_ovr = 1'b1;
            if (m_wd && m_rdn) begin
                m_wb  = !m_wb;
                m_rb  = !m_rb;
                m_wd  = 1'b0;
                m_rdn = 1'b0;
            end else begin
                if (fw) m_wd  = 1'b1;
                if (fr) m_rdn = 1'b1;
            end
            if (c) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_wb   = 1'b0;
                m_rb   = 1'b1;
                m_wd   = 1'b0;
                m_rdn  = 1'b0;
                m_ovr  = 1'b0;
            end
        end
    endtask

    // One clock: drive u_dut inputs, advance the model, compare after the edge.
    task automatic cycle(input logic c, input logic w, input logic [3:0] a,
                         input logic [11:0] d, input logic fw, input logic r,
                         input logic [3:0] ar, input logic fr);
        clr = c; we = w; wa = a; wdat = d; wfe = fw; re = r; ra = ar; rfe = fr;
        @(posedge clk);
        model_step(c, w, a, d, fw, r, ar, fr);
        #1;
        check("model", 32'({busy, wb, rb, sp, ovr, rv, rdata}),
              32'({m_busy, m_wb, m_rb, m_wd, m_ovr, m_rv, m_rdata}));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic s_idle_inputs();
        s_clr = 1'b0; s_we = 1'b0; s_wa = '0; s_wd = '0;
        s_wfe = 1'b0; s_re = 1'b0; s_ra = '0; s_rfe = 1'b0;
    endtask

    task automatic count_clear(input string nm);
        int n;
        n = 0;
        do begin
            idle();
            n++;
        end while (busy && n < 40);
        check(nm, 32'(n), 32'd16);
    endtask

    initial begin
        int n;
        // clr, we, wa, wd, wfe, re, ra, rfe | rv, rdata, wb, rb, sp, ovr
        tbl[0]  = '{1'b0, 1'b1, 4'd3, 12'h123, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'd5, 12'h555, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 12'h123, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'h123, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b1};

        clr = 0; we = 0; wa = 0; wdat = 0; wfe = 0; re = 0; ra = 0; rfe = 0;
        s_idle_inputs();

        // Reset values.
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({busy, rv, rdata}), 32'({1'b1, 1'b0, 12'h000}));
        check("rst_banks", 32'({wb, rb, sp, ovr}), 32'({1'b0, 1'b1, 1'b0, 1'b0}));
        check("rst_sgl", 32'({s_busy, s_rv, s_rdata, s_wb, s_rb}), 32'({1'b1, 1'b0, 12'h000, 1'b0, 1'b0}));
        rst = 1'b0;

        // Initial clear length and contents.
        count_clear("clear_len");
        check("sgl_clear_done", 32'(s_busy), 32'd0);
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1, 4'(a), 1'b0);
            check("clear_rd", 32'({rv, rdata}), 32'({1'b1, CV}));
        end
        idle();
        check("rd_valid_drop", 32'(rv), 32'd0);

        // Directed write / swap / overrun vectors.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].clr, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wfe,
                  tbl[i].re, tbl[i].ra, tbl[i].rfe);
            check($sformatf("vec%0d", i), 32'({rv, rdata, wb, rb, sp, ovr}),
                  32'({tbl[i].e_rv, tbl[i].e_rdata, tbl[i].e_wb, tbl[i].e_rb, tbl[i].e_sp, tbl[i].e_ovr}));
        end

        // clear_req from RUN.
        cycle(1'b1, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("clreq_state", 32'({busy, wb, rb, ovr}), 32'({1'b1, 1'b0, 1'b1, 1'b0}));
        count_clear("clreq_len");
        cycle(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        check("clreq_rd", 32'(rdata), 32'(CV));

        // Single bank, READ_LAT=2: collision returns old data.
        s_we = 1'b1; s_wa = 4'd7; s_wd = 12'h0F0; s_re = 1'b1; s_ra = 4'd7;
        idle();
        check("sgl_lat_e1", 32'(s_rv), 32'd0);
        s_idle_inputs();
        s_re = 1'b1; s_ra = 4'd7;
        idle();
        check("sgl_collide", 32'({s_rv, s_rdata}), 32'({1'b1, CV}));
        s_idle_inputs();
        idle();
        check("sgl_newdata", 32'({s_rv, s_rdata}), 32'({1'b1, 12'h0F0}));
        idle();
        check("sgl_hold", 32'({s_rv, s_rdata}), 32'({1'b0, 12'h0F0}));
        s_wfe = 1'b1; s_rfe = 1'b1;
        idle();
        s_idle_inputs();
        s_we = 1'b1; s_wa = 4'd2; s_wd = 12'h222; s_wfe = 1'b1;
        idle();
        s_idle_inputs();
        idle();
        idle();
        check("sgl_nobank", 32'({s_wb, s_rb, s_sp, s_ovr}), 32'd0);
        s_re = 1'b1; s_ra = 4'd2;
        idle();
        s_idle_inputs();
        idle();
        check("sgl_wr_kept", 32'({s_rv, s_rdata}), 32'({1'b1, 12'h222}));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(199) == 0), 1'($urandom), 4'($urandom), 12'($urandom),
                  ($urandom_range(9) == 0), 1'($urandom), 4'($urandom),
                  ($urandom_range(9) == 0));
        end

        // Reset in the middle of a clear restarts it from address 0.
        n = 0;
        while (busy && n < 40) begin
            idle();
            n++;
        end
        check("run_before_rst", 32'(busy), 32'd0);
        cycle(1'b1, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (7) idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("midclr_rst", 32'({busy, rv, rdata}), 32'({1'b1, 1'b0, 12'h000}));
        rst = 1'b0;
        count_clear("midclr_len");
        for (int a = 0; a < 16; a += 5) begin
            cycle(1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1, 4'(a), 1'b0);
            check("midclr_rd", 32'({rv, rdata}), 32'({1'b1, CV}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/frame_buffer_pp.md
Name: frame_buffer_pp

Overview:
Parametrised ping-pong frame buffer for the camera capture path. The capture side writes pixels into one bank while the display/VGA side reads the other. The two banks swap only when both sides have signalled end-of-frame. The block adds an auto-clear sequencer, a read-valid pipeline with selectable latency, overrun detection, and a single-bank mode.

Parameters:
AW, 15, address bits per bank; each bank holds 2**AW words
DW, 12, data bits per word (RGB444)
DUAL, 1, 1 = two banks with ping-pong swap; 0 = single bank, no swap
READ_LAT, 1, read latency in cycles, legal values 1 or 2 (2 adds an output register)
CLR_VAL, 0, DW-bit value written to every word during clear

Ports:
clk  in  1  single clock for both ports
rst  in  1  asynchronous, active-high reset
clear_req  in  1  pulse; request a full clear of all banks
wr_en  in  1  write strobe
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_frame_end  in  1  pulse; writer finished its frame
rd_en  in  1  read strobe
rd_addr  in  AW  read address
rd_frame_end  in  1  pulse; reader finished its frame
rd_data  out  DW  read data
rd_valid  out  1  rd_data holds data for a read issued READ_LAT cycles earlier
busy  out  1  clear sequence in progress
wr_bank  out  1  bank currently written
rd_bank  out  1  bank currently read
swap_pending  out  1  writer has finished; waiting on the reader
overrun  out  1  sticky; writer attempted access while swap pending

Behaviour:
- Control state is reset by rst: FSM = CLEAR, clr_addr = 0, wr_bank = 0, rd_bank = DUAL, wr_done = rd_done = 0, overrun = 0.
- During rst, output values are: rd_data = 0, rd_valid = 0, busy = 1.
- RAM contents are not reset; the CLEAR state initialises them.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle, writes CLR_VAL at clr_addr in every bank in parallel, then increments clr_addr.
  - Occupies exactly 2**AW cycles. When clr_addr = 2**AW-1 it is written and the FSM moves to RUN next cycle; busy drops at that edge.
  - wr_en, rd_en, both frame_end inputs and clear_req are ignored. rd_valid stays 0.
- RUN:
  - A clear_req pulse returns the FSM to CLEAR on the next cycle with clr_addr = 0.
  - The same clear_req also zeroes wr_bank, wr_done, rd_done and overrun, and sets rd_bank = DUAL.
- Write (RUN, wr_en = 1, swap_pending = 0): ram[wr_bank][wr_addr] <= wr_data.
- Write attempted while swap_pending = 1: the write is dropped and overrun is set (sticky). A wr_frame_end in this state also sets overrun.
- Read (RUN, rd_en = 1): ram[rd_bank][rd_addr] is sampled on the edge.
  - READ_LAT = 1: rd_data and rd_valid update at that edge.
  - READ_LAT = 2: one further register stage.
  - rd_valid is rd_en delayed by READ_LAT; it is 0 on cycles with no read. rd_data holds its last value when rd_valid = 0.
- Same-bank, same-address read and write in one cycle (only possible when DUAL = 0): read-before-write; the old data is returned.
- Swap (DUAL = 1):
  - wr_frame_end sets wr_done (swap_pending = wr_done). rd_frame_end sets rd_done.
  - On the cycle where wr_done & rd_done are both registered set, wr_bank and rd_bank toggle at the next edge and both flags clear. Swap latency is 1 cycle after the later flag.
  - Simultaneous wr_frame_end and rd_frame_end: both flags set at one edge; swap occurs at the following edge.
  - A repeated rd_frame_end while rd_done is already set is harmless and has no effect.
  - A read in flight across a swap completes from the bank sampled at issue.
- DUAL = 0:
  - One bank only; wr_bank = rd_bank = 0.
  - Frame-end inputs are ignored; swap_pending = 0 and overrun = 0 always.
- Reset asserted mid-clear or mid-frame: the clear restarts from address 0. The pipeline is flushed (rd_valid = 0).
- Address arithmetic: clr_addr is AW+1 bits internally so the terminal count is detected without wrap. Write and read addresses use the full AW range; no out-of-range case exists.

Test Plan:
1. AW=4, DUAL=1, CLR_VAL=12'hABC; release rst → busy=1 for exactly 16 cycles, then 0; reading all 16 addresses of rd_bank returns 12'hABC with rd_valid exactly 1 cycle after rd_en.
2. After clear, write addr 3 = 12'h123 into bank 0; rd_addr 3 before swap → 12'hABC; pulse wr_frame_end then rd_frame_end → wr_bank=1, rd_bank=0 one cycle after the rd pulse; read addr 3 → 12'h123.
3. Pulse wr_frame_end only; then wr_en addr 5 = 12'h555 → swap_pending=1, overrun=1; after swap, bank 0 addr 5 still reads 12'hABC.
4. wr_frame_end and rd_frame_end in the same cycle → banks toggle exactly one edge later; then clear_req → busy=1 for 16 cycles, wr_bank=0, overrun=0.
5. DUAL=0, READ_LAT=2: write and read addr 7 in the same cycle with new data 12'h0F0 over old 12'hABC → rd_data=12'hABC with rd_valid two cycles later; a read next cycle returns 12'h0F0; frame-end pulses leave wr_bank=rd_bank=0.
6. Assert rst at clear cycle 8, release → busy restarts and lasts a full 16 cycles; rd_valid=0 throughout.
